mul_issue_ctrl: RTL and testbench
=================================

// Module: mul_issue_ctrl
// PURPOSE
//  Issue/response stage directly upstream of the rv32im multicycle multiplier.
//  - Accepts MUL/MULH/MULHSU/MULHU requests from the core control FSM.
//  - Drives the multiplier's valid/ready handshake and holds its operands stable for the whole operation.
//  - Captures the product and returns it with the destination register index.
//  - Short-cuts repeated operand pairs using a 1-entry result cache and reuse of the low product half.
// PARAMETERS
//  REUSE_EN   1   1: enables the exact-hit and low-half reuse paths; 0: every request goes to the multiplier.
//  HIT_CNT_W  16  width of the saturating reuse-hit counter.
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high reset
//  req_valid    in   1   request present
//  req_ready    out  1   request accepted when req_valid & req_ready
//  req_op       in   2   00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//  req_rs1      in   32  factor1
//  req_rs2      in   32  factor2
//  req_rd       in   5   destination register index, returned unchanged
//  rsp_valid    out  1   result present
//  rsp_ready    in   1   result consumed when rsp_valid & rsp_ready
//  rsp_data     out  32  result
//  rsp_rd       out  5   rd of the request
//  mul_factor1  out  32  to multiplier
//  mul_factor2  out  32  to multiplier
//  mul_op       out  2   to multiplier; also selects its product half
//  mul_valid    out  1   start pulse to multiplier
//  mul_ready    in   1   one-cycle completion pulse from multiplier
//  mul_product  in   32  from multiplier; combinational on mul_op
//  hit_count    out  HIT_CNT_W  saturating count of requests served without a multiply
// BEHAVIOUR
//  Reset values: state IDLE; req_ready=1; rsp_valid=0; mul_valid=0; hit_count=0; cache invalid.
//  Data registers (operands, op, rd, result) are not reset.
//  States:
//  - IDLE: req_ready=1. On accept, latch op/rs1/rs2/rd, then:
//    - exact hit (cache valid, same op/rs1/rs2) -> RESP, using the cached result;
//    - low-half reuse (cache valid, same rs1/rs2, req_op==MUL, cached op!=MUL) -> REUSE;
//    - otherwise -> ISSUE.
//    With REUSE_EN=0, every accept goes to ISSUE.
//  - ISSUE: mul_valid=1 for exactly one cycle -> WAIT.
//  - WAIT: mul_valid=0. On mul_ready, capture mul_product into the result and cache, set the cache valid -> RESP.
//  - REUSE: mul_op=00 for one cycle; the multiplier still holds the full signed-corrected 64-bit product.
//    Capture mul_product (low half); cache op becomes MUL -> RESP.
//  - RESP: rsp_valid=1, with rsp_data/rsp_rd stable. On rsp_ready -> IDLE; rsp_valid drops on the next cycle.
//  mul_factor1, mul_factor2 and mul_op come from the latched registers in every state. They never change between ISSUE and WAIT capture.
//  The multiplier's sign fix-up and half select read them live.
//  req_ready=0 outside IDLE; requests are never dropped or queued.
//  Latency, with acceptance at cycle 0:
//  - miss: mul_valid in cycle 1, mul_ready in cycle 35, rsp_valid first in cycle 36;
//  - exact hit: rsp_valid in cycle 1;
//  - reuse: rsp_valid in cycle 2.
//  hit_count increments on every exact hit or reuse and saturates at all-ones.
//  Boundaries:
//  - rsp_ready held low: stay in RESP indefinitely; req_ready stays 0.
//  - mul_ready outside WAIT: ignored.
//  - Issuing after a completion: a new ISSUE can only start at least 2 cycles after a mul_ready pulse (it passes through RESP and IDLE).
//    So the multiplier is always in IDLE with ready=0 when it is issued.
//  - Reset mid-operation: both blocks reset together; the cache is invalidated, so stale multiplier product state is never reused.
//  - Operands equal to the cached pair with the same non-MUL op: exact hit, no multiply.
// STRUCTURE
//  Package mul_ctrl_pkg: MULop encodings (MUL/MULH/MULHSU/MULHU), one-hot state bit indices, XLEN=32.
//  Sub-module mul_result_cache: tag registers (op, rs1, rs2), result register, valid bit.
//  - outputs: exact_hit, low_reuse;
//  - inputs: fill/update strobe, invalidate on reset.
//  The FSM, hit counter and port muxing stay in mul_issue_ctrl.
// TESTING
//  - MUL 7 x 6, cold cache: mul_valid exactly once; rsp_data=42 in cycle 36; rsp_rd echoed; hit_count=0.
//  - MULH 0xFFFFFFFF x 0xFFFFFFFF, then the same MULH: second response in cycle 1 with rsp_data=0, no mul_valid, hit_count=1.
//  - MULHU 0x80000000 x 4 -> 0x00000002.
//    Then MUL with the same operands -> REUSE, rsp_data=0 in cycle 2, mul_op=00 during REUSE, no mul_valid.
//  - MULHSU 0xFFFFFFFE x 3 -> 0xFFFFFFFF.
//    Hold rsp_ready=0 for 10 cycles: rsp_valid and rsp_data stable, req_ready=0.
//  - Assert reset in cycle 10 of a miss, then reissue the same request: full miss path, correct result, hit_count=0.
//  - REUSE_EN=0 build: repeated identical requests each issue mul_valid; hit_count stays 0.

Source files
------------

// File: rtl/mul_ctrl_pkg.sv
// Shared definitions for the multiplier issue controller: op encodings,
// one-hot FSM state layout and the cache tag payload.
package mul_ctrl_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 2;
    localparam int unsigned RD_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    // One-hot state bit positions; handshake outputs are taken straight from these flops.
    localparam int unsigned ST_IDLE_B  = 0;
    localparam int unsigned ST_ISSUE_B = 1;
    localparam int unsigned ST_WAIT_B  = 2;
    localparam int unsigned ST_REUSE_B = 3;
    localparam int unsigned ST_RESP_B  = 4;
    localparam int unsigned ST_W       = 5;

    typedef enum logic [ST_W-1:0] {
        S_IDLE  = 5'b00001,
        S_ISSUE = 5'b00010,
        S_WAIT  = 5'b00100,
        S_REUSE = 5'b01000,
        S_RESP  = 5'b10000
    } state_e;

    typedef struct packed {
        mul_op_e         op;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } mul_tag_t;

endpackage

// File: rtl/mul_result_cache.sv
// One-entry result cache keyed by (op, rs1, rs2); also flags when a MUL can
// be served from the low half of the product still held by the multiplier.
module mul_result_cache
    import mul_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            i_fill,
    input  mul_tag_t        i_fill_tag,
    input  logic [XLEN-1:0] i_fill_data,
    input  mul_tag_t        i_lookup_tag,
    output logic            o_exact_hit_c,
    output logic            o_low_reuse_c,
    output logic [XLEN-1:0] o_result
);

    logic            r_valid;
    mul_tag_t        r_tag;
    logic [XLEN-1:0] r_result;
    logic            w_same_pair;

    // Only the valid bit is reset; tag and data are qualified by it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_fill) begin
            r_tag    <= i_fill_tag;
            r_result <= i_fill_data;
        end
    end

    assign w_same_pair   = (r_tag.rs1 == i_lookup_tag.rs1) && (r_tag.rs2 == i_lookup_tag.rs2);
    assign o_exact_hit_c = r_valid && w_same_pair && (r_tag.op == i_lookup_tag.op);
    assign o_low_reuse_c = r_valid && w_same_pair && (i_lookup_tag.op == OP_MUL)
                           && (r_tag.op != OP_MUL);
    assign o_result      = r_result;

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/response stage in front of the multicycle multiplier: drives its
// start handshake, returns products with rd, and short-cuts repeated pairs.
module mul_issue_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter bit          REUSE_EN  = 1'b1,
    parameter int unsigned HIT_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [OP_W-1:0]      req_op,
    input  logic [XLEN-1:0]      req_rs1,
    input  logic [XLEN-1:0]      req_rs2,
    input  logic [RD_W-1:0]      req_rd,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [XLEN-1:0]      rsp_data,
    output logic [RD_W-1:0]      rsp_rd,
    output logic [XLEN-1:0]      mul_factor1,
    output logic [XLEN-1:0]      mul_factor2,
    output logic [OP_W-1:0]      mul_op,
    output logic                 mul_valid,
    input  logic                 mul_ready,
    input  logic [XLEN-1:0]      mul_product,
    output logic [HIT_CNT_W-1:0] hit_count
);

    state_e                r_state;
    state_e                w_state_nxt;
    mul_tag_t              r_tag;
    logic [RD_W-1:0]       r_rd;
    logic [XLEN-1:0]       r_result;
    logic [HIT_CNT_W-1:0]  r_hit_cnt;

    mul_tag_t              w_lookup_tag;
    logic                  w_accept;
    logic                  w_exact_hit_c;
    logic                  w_low_reuse_c;
    logic                  w_hit;
    logic                  w_reuse;
    logic                  w_capture;
    logic [XLEN-1:0]       w_cache_result;

    assign w_lookup_tag = '{op: mul_op_e'(req_op), rs1: req_rs1, rs2: req_rs2};
    assign w_accept     = req_valid && r_state[ST_IDLE_B];
    assign w_hit        = REUSE_EN && w_exact_hit_c;
    assign w_reuse      = REUSE_EN && w_low_reuse_c;
    // Product is taken on the multiplier's completion pulse, or directly in REUSE.
    assign w_capture    = (r_state[ST_WAIT_B] && mul_ready) || r_state[ST_REUSE_B];

    mul_result_cache u_cache (
        .clk           (clk),
        .reset         (reset),
        .i_fill        (w_capture),
        .i_fill_tag    (r_tag),
        .i_fill_data   (mul_product),
        .i_lookup_tag  (w_lookup_tag),
        .o_exact_hit_c (w_exact_hit_c),
        .o_low_reuse_c (w_low_reuse_c),
        .o_result      (w_cache_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_hit) begin
                        w_state_nxt = S_RESP;
                    end else if (w_reuse) begin
                        w_state_nxt = S_REUSE;
                    end else begin
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (mul_ready) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_REUSE: w_state_nxt = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request payload and result; not reset, always written before use.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tag <= w_lookup_tag;
            r_rd  <= req_rd;
        end
        if (w_accept && w_hit) begin
            r_result <= w_cache_result;
        end else if (w_capture) begin
            r_result <= mul_product;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_cnt <= '0;
        end else if (w_accept && (w_hit || w_reuse) && (r_hit_cnt != '1)) begin
            r_hit_cnt <= r_hit_cnt + HIT_CNT_W'(1);
        end
    end

    assign req_ready   = r_state[ST_IDLE_B];
    assign mul_valid   = r_state[ST_ISSUE_B];
    assign rsp_valid   = r_state[ST_RESP_B];
    assign rsp_data    = r_result;
    assign rsp_rd      = r_rd;
    // A reuse is only taken for a MUL request, so the latched op already selects the low half.
    assign mul_op      = r_tag.op;
    assign mul_factor1 = r_tag.rs1;
    assign mul_factor2 = r_tag.rs2;
    assign hit_count   = r_hit_cnt;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl: instance 0 with reuse enabled, instance 1
// with reuse disabled, each in front of a 34-cycle multiplier model.
module tb_mul_issue_ctrl;

    typedef struct {
        int          inst;
        int          hold;
        logic [1:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_mulv;
        logic [15:0] exp_hits;
        logic [1:0]  exp_op1;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_op      [2];
    logic [31:0] req_rs1     [2];
    logic [31:0] req_rs2     [2];
    logic [4:0]  req_rd      [2];
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data    [2];
    logic [4:0]  rsp_rd      [2];
    logic [31:0] mul_factor1 [2];
    logic [31:0] mul_factor2 [2];
    logic [1:0]  mul_op      [2];
    logic [1:0]  mul_valid;
    logic [1:0]  mul_ready;
    logic [31:0] mul_product [2];
    logic [15:0] hit_count   [2];

    int checks = 0;
    int errors = 0;

    vec_t tbl [16];

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_full(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = (op == 2'b11) ? {32'h0, a} : {{32{a[31]}}, a};
        eb = (op[1] == 1'b1) ? {32'h0, b} : {{32{b[31]}}, b};
        return ea * eb;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [63:0] r_p64;
        int          r_cnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= 0;
                r_p64 <= '0;
            end else if (mul_valid[g]) begin
                r_cnt <= 34;
                r_p64 <= ref_full(mul_op[g], mul_factor1[g], mul_factor2[g]);
            end else if (r_cnt != 0) begin
                r_cnt <= r_cnt - 1;
            end
        end

        assign mul_ready[g]   = (r_cnt == 1);
        assign mul_product[g] = (mul_op[g] == 2'b00) ? r_p64[31:0] : r_p64[63:32];

        mul_issue_ctrl #(
            .REUSE_EN  (g == 0),
            .HIT_CNT_W (16)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_op      (req_op[g]),
            .req_rs1     (req_rs1[g]),
            .req_rs2     (req_rs2[g]),
            .req_rd      (req_rd[g]),
            .rsp_valid   (rsp_valid[g]),
            .rsp_ready   (rsp_ready[g]),
            .rsp_data    (rsp_data[g]),
            .rsp_rd      (rsp_rd[g]),
            .mul_factor1 (mul_factor1[g]),
            .mul_factor2 (mul_factor2[g]),
            .mul_op      (mul_op[g]),
            .mul_valid   (mul_valid[g]),
            .mul_ready   (mul_ready[g]),
            .mul_product (mul_product[g]),
            .hit_count   (hit_count[g])
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input int idx, input string tag);
        check({tag, " req_ready"}, 64'(req_ready[idx]), 64'd1);
        check({tag, " rsp_valid"}, 64'(rsp_valid[idx]), 64'd0);
        check({tag, " mul_valid"}, 64'(mul_valid[idx]), 64'd0);
        check({tag, " hit_count"}, 64'(hit_count[idx]), 64'd0);
    endtask

    // Issue one request, measure latency from acceptance, then drain the response.
    task automatic run_req(input vec_t v, input string tag);
        int         idx;
        int         cyc;
        int         mv;
        logic [1:0] op1;
        idx = v.inst;
        @(negedge clk);
        rsp_ready[idx] = (v.hold == 0);
        req_valid[idx] = 1'b1;
        req_op[idx]    = v.op;
        req_rs1[idx]   = v.rs1;
        req_rs2[idx]   = v.rs2;
        req_rd[idx]    = v.rd;
        cyc = 0;
        while (req_ready[idx] !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " accept"}, 64'(req_ready[idx]), 64'd1);
        @(posedge clk);
        #1 req_valid[idx] = 1'b0;
        mv  = 0;
        op1 = 2'bxx;
        for (cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (mul_valid[idx]) mv++;
            if (cyc == 1) op1 = mul_op[idx];
            if (rsp_valid[idx]) break;
        end
        check({tag, " latency"},   64'(cyc), 64'(v.exp_lat));
        check({tag, " mul_valid"}, 64'(mv), 64'(v.exp_mulv));
        check({tag, " mul_op@1"},  64'(op1), 64'(v.exp_op1));
        check({tag, " rsp_data"},  64'(rsp_data[idx]), 64'(v.exp_data));
        check({tag, " rsp_rd"},    64'(rsp_rd[idx]), 64'(v.rd));
        check({tag, " hit_count"}, 64'(hit_count[idx]), 64'(v.exp_hits));
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            check($sformatf("%s hold%0d", tag, i),
                  {29'h0, rsp_valid[idx], req_ready[idx], mul_valid[idx], rsp_data[idx]},
                  {29'h0, 1'b1, 1'b0, 1'b0, v.exp_data});
        end
        rsp_ready[idx] = 1'b1;
        @(negedge clk);
        check({tag, " release"}, {62'h0, rsp_valid[idx], req_ready[idx]}, 64'b01);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        //          inst hold op     rs1           rs2           rd     data          lat mv hits   op1
        tbl[0]  = '{0, 0, 2'b00, 32'd7,        32'd6,        5'd3,  32'd42,        36, 1, 16'd0, 2'b00};
        tbl[1]  = '{0, 0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'h0,         36, 1, 16'd0, 2'b01};
        tbl[2]  = '{0, 0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'h0,          1, 0, 16'd1, 2'b01};
        tbl[3]  = '{0, 0, 2'b11, 32'h80000000, 32'd4,        5'd7,  32'h2,         36, 1, 16'd1, 2'b11};
        tbl[4]  = '{0, 0, 2'b00, 32'h80000000, 32'd4,        5'd8,  32'h0,          2, 0, 16'd2, 2'b00};
        tbl[5]  = '{0, 0, 2'b00, 32'h80000000, 32'd4,        5'd9,  32'h0,          1, 0, 16'd3, 2'b00};
        tbl[6]  = '{0, 0, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 32'hFFFFFFFE,  36, 1, 16'd3, 2'b11};
        tbl[7]  = '{0, 0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'h1,          2, 0, 16'd4, 2'b00};
        tbl[8]  = '{0, 0, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'hFFFFFFFE,  36, 1, 16'd4, 2'b11};
        tbl[9]  = '{0, 10, 2'b10, 32'hFFFFFFFE, 32'd3,       5'd13, 32'hFFFFFFFF,  36, 1, 16'd4, 2'b10};
        // After the mid-operation reset: the previously cached pair must miss.
        tbl[10] = '{0, 0, 2'b10, 32'hFFFFFFFE, 32'd3,        5'd13, 32'hFFFFFFFF,  36, 1, 16'd0, 2'b10};
        tbl[11] = '{0, 0, 2'b00, 32'd1000,     32'd1000,     5'd14, 32'h000F4240,  36, 1, 16'd0, 2'b00};
        tbl[12] = '{1, 0, 2'b00, 32'd7,        32'd6,        5'd1,  32'd42,        36, 1, 16'd0, 2'b00};
        tbl[13] = '{1, 0, 2'b00, 32'd7,        32'd6,        5'd2,  32'd42,        36, 1, 16'd0, 2'b00};
        tbl[14] = '{1, 0, 2'b11, 32'h80000000, 32'd4,        5'd3,  32'h2,         36, 1, 16'd0, 2'b11};
        tbl[15] = '{1, 0, 2'b00, 32'h80000000, 32'd4,        5'd4,  32'h0,         36, 1, 16'd0, 2'b00};

        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        for (int i = 0; i < 2; i++) begin
            req_op[i]  = '0;
            req_rs1[i] = '0;
            req_rs2[i] = '0;
            req_rd[i]  = '0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle(0, "reset0");
        check_idle(1, "reset1");

        for (int i = 0; i < 10; i++) begin
            run_req(tbl[i], $sformatf("v%0d", i));
        end

        // Abort a miss with a reset in cycle 10 after acceptance.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_op[0]    = 2'b00;
        req_rs1[0]   = 32'd1000;
        req_rs2[0]   = 32'd1000;
        req_rd[0]    = 5'd14;
        begin
            int cyc;
            cyc = 0;
            while (req_ready[0] !== 1'b1 && cyc < 50) begin
                @(negedge clk);
                cyc++;
            end
        end
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        repeat (10) @(negedge clk);
        check("abort in_wait", {62'h0, rsp_valid[0], req_ready[0]}, 64'b00);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle(0, "midreset0");
        check_idle(1, "midreset1");
        repeat (40) @(negedge clk);
        check("abort no_rsp", 64'(rsp_valid[0]), 64'd0);

        for (int i = 10; i < 16; i++) begin
            run_req(tbl[i], $sformatf("v%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
